// File: rtl/fc_dec_pkg.sv
// fc_dec_pkg: shared types and defaults for the Ascon-128 decryption
// fault-countermeasure front end.
//   DEF_*       default widths / limits for fc_dec and its interface
//   fc_state_e  FSM encoding (IDLE/WAIT/CMP/DONE)
//   idx_w()     counter width helper, never narrower than one bit
package fc_dec_pkg;

    localparam int DEF_PT_W    = 40;
    localparam int DEF_TAG_W   = 128;
    localparam int DEF_CHUNK   = 32;
    localparam int DEF_TIMEOUT = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } fc_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_dec_if.sv
// fc_dec_if: host- and core-side signals of fc_dec.
//   Host:  decryption_start, tag_rx -> plain_text, auth_ok, fault,
//          decryption_ready (and fault_cnt when FC_DEC_FAULT_CNT_EN is defined)
//   Cores: core_start -> pt_a/pt_b, tag_a/tag_b, ready_a/ready_b
//   modport slave  : fc_dec side
//   modport master : host/core model side
interface fc_dec_if
    import fc_dec_pkg::*;
#(
    parameter int Y     = DEF_PT_W,
    parameter int TAG_W = DEF_TAG_W
) ();

    logic             decryption_start;
    logic [TAG_W-1:0] tag_rx;
    logic             core_start;
    logic [Y-1:0]     pt_a;
    logic [Y-1:0]     pt_b;
    logic [TAG_W-1:0] tag_a;
    logic [TAG_W-1:0] tag_b;
    logic             ready_a;
    logic             ready_b;
    logic [Y-1:0]     plain_text;
    logic             auth_ok;
    logic             fault;
    logic             decryption_ready;
`ifdef FC_DEC_FAULT_CNT_EN
    logic [7:0]       fault_cnt;
`endif

    modport slave (
        input  decryption_start, tag_rx, pt_a, pt_b, tag_a, tag_b, ready_a, ready_b,
        output core_start, plain_text, auth_ok, fault, decryption_ready
`ifdef FC_DEC_FAULT_CNT_EN
        , output fault_cnt
`endif
    );

    modport master (
        output decryption_start, tag_rx, pt_a, pt_b, tag_a, tag_b, ready_a, ready_b,
        input  core_start, plain_text, auth_ok, fault, decryption_ready
`ifdef FC_DEC_FAULT_CNT_EN
        , input fault_cnt
`endif
    );

endinterface

// File: rtl/fc_dec_tag_cmp.sv
// fc_tag_cmp: fixed-time chunked tag comparator.
//   clk, rst       clock, async active-high reset
//   clr            clears chunk index and both accumulators (new operation)
//   en             one chunk compared per cycle while high
//   tag_a/b/rx     core A, core B and received tags (held stable by the caller)
//   sel            current chunk index
//   last           high on the final chunk cycle
//   diff_rx        sticky: tag_a differs from tag_rx in some chunk seen so far
//   diff_ab        sticky: tag_a differs from tag_b in some chunk seen so far
// Always walks all chunks; the result never affects how long the walk takes.
module fc_tag_cmp
    import fc_dec_pkg::*;
#(
    parameter  int TAG_W = DEF_TAG_W,
    parameter  int CHUNK = DEF_CHUNK,
    localparam int NCH   = TAG_W / CHUNK,
    localparam int IW    = idx_w(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [TAG_W-1:0] tag_a,
    input  logic [TAG_W-1:0] tag_b,
    input  logic [TAG_W-1:0] tag_rx,
    output logic [IW-1:0]    sel,
    output logic             last,
    output logic             diff_rx,
    output logic             diff_ab
);

    logic [NCH-1:0][CHUNK-1:0] a_ch, b_ch, rx_ch;
    logic [IW-1:0]             sel_q;
    logic                      diff_rx_q, diff_ab_q;

    assign a_ch  = tag_a;
    assign b_ch  = tag_b;
    assign rx_ch = tag_rx;

    assign last    = en && (sel_q == IW'(NCH - 1));
    assign sel     = sel_q;
    assign diff_rx = diff_rx_q;
    assign diff_ab = diff_ab_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= '0;
            diff_rx_q <= 1'b0;
            diff_ab_q <= 1'b0;
        end else if (clr) begin
            sel_q     <= '0;
            diff_rx_q <= 1'b0;
            diff_ab_q <= 1'b0;
        end else if (en) begin
            diff_rx_q <= diff_rx_q | (|(a_ch[sel_q] ^ rx_ch[sel_q]));
            diff_ab_q <= diff_ab_q | (|(a_ch[sel_q] ^ b_ch[sel_q]));
            sel_q     <= last ? '0 : sel_q + 1'b1;
        end
    end

endmodule

// File: rtl/fc_dec.sv
// fc_dec: fault-countermeasure front end for redundant Ascon-128 decryption.
//   clk, rst  clock, async active-high reset
//   bus       fc_dec_if.slave (host request/response + two-core handshake)
// Starts both cores, captures the first result from each, compares tags in
// fixed time and releases plaintext only when the cores agree and the tag
// verifies. Results hold until the next accepted start.
// Optional: FC_DEC_FAULT_CNT_EN adds bus.fault_cnt, a saturating count of
// completions that reported a fault (cleared only by rst).
module fc_dec
    import fc_dec_pkg::*;
#(
    parameter int Y       = DEF_PT_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int CHUNK   = DEF_CHUNK,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic     clk,
    input  logic     rst,
    fc_dec_if.slave  bus
);

    localparam int TMR_W = idx_w(TIMEOUT);
    localparam int IW    = idx_w(TAG_W / CHUNK);

    fc_state_e        state_q, state_d;
    logic             core_start_q;
    logic [TAG_W-1:0] tag_rx_q, tag_a_q, tag_b_q;
    logic [Y-1:0]     pt_a_q, pt_b_q, pt_out_q;
    logic             seen_a_q, seen_b_q, timeout_q, pt_ne_q;
    logic             auth_q, fault_q;
    logic [TMR_W-1:0] timer_q;

    logic             accept, expired, both_seen, done;
    logic             cmp_last, diff_rx, diff_ab;
    logic [IW-1:0]    cmp_sel;
    logic             fault_c, auth_c;
    logic [Y-1:0]     pt_c;

    assign accept    = (state_q == ST_IDLE) && bus.decryption_start;
    assign expired   = (timer_q == TMR_W'(TIMEOUT - 1));
    // include this cycle's pulses so a simultaneous pair goes straight to CMP
    assign both_seen = (seen_a_q | bus.ready_a) & (seen_b_q | bus.ready_b);
    assign done      = (state_q == ST_DONE);

    fc_tag_cmp #(.TAG_W(TAG_W), .CHUNK(CHUNK)) u_cmp (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (state_q == ST_CMP),
        .tag_a   (tag_a_q),
        .tag_b   (tag_b_q),
        .tag_rx  (tag_rx_q),
        .sel     (cmp_sel),
        .last    (cmp_last),
        .diff_rx (diff_rx),
        .diff_ab (diff_ab)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)    state_d = ST_WAIT;
            // expiry is checked first: a late ready never rescues a timeout
            ST_WAIT: if (expired)        state_d = ST_DONE;
                     else if (both_seen) state_d = ST_CMP;
            ST_CMP:  if (cmp_last)  state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    assign fault_c = timeout_q | diff_ab | pt_ne_q;
    assign auth_c  = ~fault_c & ~diff_rx;
    assign pt_c    = auth_c ? pt_a_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            core_start_q <= 1'b0;
            tag_rx_q     <= '0;
            tag_a_q      <= '0;
            tag_b_q      <= '0;
            pt_a_q       <= '0;
            pt_b_q       <= '0;
            seen_a_q     <= 1'b0;
            seen_b_q     <= 1'b0;
            timeout_q    <= 1'b0;
            pt_ne_q      <= 1'b0;
            timer_q      <= '0;
            auth_q       <= 1'b0;
            fault_q      <= 1'b0;
            pt_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= accept;
            if (accept) begin
                tag_rx_q  <= bus.tag_rx;
                seen_a_q  <= 1'b0;
                seen_b_q  <= 1'b0;
                timer_q   <= '0;
                timeout_q <= 1'b0;
                pt_ne_q   <= 1'b0;
                auth_q    <= 1'b0;
                fault_q   <= 1'b0;
                pt_out_q  <= '0;
            end
            if (state_q == ST_WAIT) begin
                timer_q <= timer_q + 1'b1;
                if (expired) timeout_q <= 1'b1;
                // only the first pulse from each core is trusted
                if (bus.ready_a && !seen_a_q) begin
                    pt_a_q   <= bus.pt_a;
                    tag_a_q  <= bus.tag_a;
                    seen_a_q <= 1'b1;
                end
                if (bus.ready_b && !seen_b_q) begin
                    pt_b_q   <= bus.pt_b;
                    tag_b_q  <= bus.tag_b;
                    seen_b_q <= 1'b1;
                end
            end
            if (state_q == ST_CMP && cmp_sel == '0)
                pt_ne_q <= |(pt_a_q ^ pt_b_q);
            if (done) begin
                auth_q   <= auth_c;
                fault_q  <= fault_c;
                pt_out_q <= pt_c;
            end
        end
    end

    // Results are driven straight from the final flags during DONE and from
    // the hold registers afterwards, so they appear with decryption_ready.
    assign bus.core_start       = core_start_q;
    assign bus.decryption_ready = done;
    assign bus.auth_ok          = done ? auth_c  : auth_q;
    assign bus.fault            = done ? fault_c : fault_q;
    assign bus.plain_text       = done ? pt_c    : pt_out_q;

`ifdef FC_DEC_FAULT_CNT_EN
    logic [7:0] fault_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault_cnt_q <= '0;
        else if (done && fault_c && fault_cnt_q != 8'hFF)
            fault_cnt_q <= fault_cnt_q + 8'd1;
    end

    assign bus.fault_cnt = fault_cnt_q;
`endif

endmodule
